// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory data register with its own memory-side req/ack port.
// The register always drives BusMuxIn. It loads from BusMuxOut (enable), from
// a memory read, or is written to memory, with a timeout on mem_ack.
//
// Handshake: mem_req rises the cycle after a read/write is accepted and holds
// (with mem_we, mem_addr, mem_wdata, mem_be stable) until the cycle in which
// mem_ack is sampled high, or until the wait counter hits TIMEOUT (abort,
// err set). mem_ack is a one-cycle completion strobe and is ignored in IDLE.
//
// Optional feature macro: MDR_BYTE_LANES_EN (byte/half lanes, DATA_W=32 only).
// Without it every access is a full word and size/sign_ext are ignored.
// fsm_state exposes the controller state (0 IDLE, 1 RD_WAIT, 2 WR_WAIT).
module mdr_mem_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                enable,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   BusMuxOut,
    output logic [DATA_W-1:0]   BusMuxIn,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_req,
    output logic                mem_we,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          fsm_state
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mdr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              acc_misaligned;
    logic [BE_W-1:0]   acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rd_fmt;

    assign BusMuxIn  = mdr;
    assign fsm_state = state;
    assign cnt_next  = cnt + 1'b1;

`ifdef MDR_BYTE_LANES_EN
    // Access attributes latched at command accept, used to format read data.
    logic [1:0] lat_size;
    logic       lat_sext;
    logic [1:0] lat_lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane placement of write data, byte enables and alignment check.
    always_comb begin
        acc_misaligned = 1'b0;
        acc_be         = '1;
        acc_wdata      = mdr;
        case (size)
            2'b10: begin
                acc_be            = '0;
                acc_be[addr[1:0]] = 1'b1;
                acc_wdata         = {4{mdr[7:0]}};
            end
            2'b01: begin
                acc_be         = addr[1] ? 4'b1100 : 4'b0011;
                acc_wdata      = {2{mdr[15:0]}};
                acc_misaligned = addr[0];
            end
            default: ;
        endcase
    end

    // Right-justify the selected read lane and extend it.
    always_comb begin
        byte_v = mem_rdata[{lat_lane, 3'b000} +: 8];
        half_v = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rd_fmt = mem_rdata;
        case (lat_size)
            2'b10:   rd_fmt = {{24{lat_sext & byte_v[7]}}, byte_v};
            2'b01:   rd_fmt = {{16{lat_sext & half_v[15]}}, half_v};
            default: rd_fmt = mem_rdata;
        endcase
    end

    // Capture access attributes whenever a command is accepted.
    always_ff @(posedge clock) begin
        if (clear) begin
            lat_size <= 2'b00;
            lat_sext <= 1'b0;
            lat_lane <= 2'b00;
        end else if (state == IDLE && (read || write)) begin
            lat_size <= size;
            lat_sext <= sign_ext;
            lat_lane <= addr[1:0];
        end
    end
`else
    // Full-word only: size and sign_ext have no effect.
    logic unused_narrow;
    assign unused_narrow = ^{size, sign_ext};

    // Word access: all byte enables, MDR as write data, raw read data.
    always_comb begin
        acc_misaligned = 1'b0;
        acc_be         = '1;
        acc_wdata      = mdr;
        rd_fmt         = mem_rdata;
    end
`endif

    // Controller: command accept, wait for ack or timeout, registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            mdr       <= '0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        if (acc_misaligned) begin
                            err <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            state    <= read ? RD_WAIT : WR_WAIT;
                            mem_req  <= 1'b1;
                            mem_we   <= ~read;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            mem_addr <= addr;
                            mem_be   <= acc_be;
                            if (!read) begin
                                mem_wdata <= acc_wdata;
                            end
                        end
                    end else if (enable) begin
                        mdr <= BusMuxOut;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // An ack on the limit cycle wins over the abort.
                    if (mem_ack) begin
                        if (state == RD_WAIT) begin
                            mdr <= rd_fmt;
                        end
                        done    <= 1'b1;
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cnt_next == CNT_LIMIT) begin
                        err     <= 1'b1;
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        cnt     <= cnt_next;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed testbench for mdr_mem_port (DATA_W=32, ADDR_W=9, TIMEOUT=15).
// Byte-lane vectors run only when MDR_BYTE_LANES_EN is defined.
module tb_mdr_mem_port;

    logic        clock = 1'b0;
    logic        clear;
    logic        enable;
    logic        read;
    logic        write;
    logic [8:0]  addr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] BusMuxOut;
    logic [31:0] BusMuxIn;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Values captured on the first request cycle of a transaction.
    logic        cap_we;
    logic [8:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_err;
    int          req_cycles;
    logic        saw_done;

    mdr_mem_port #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .enable(enable), .read(read),
        .write(write), .addr(addr), .size(size), .sign_ext(sign_ext),
        .BusMuxOut(BusMuxOut), .BusMuxIn(BusMuxIn), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_req(mem_req),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .fsm_state(fsm_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mdr(input string tag);
        check(tag, BusMuxIn, exp_q.pop_front());
    endtask

    // Driver: load MDR from the bus in IDLE.
    task automatic load_mdr(input logic [31:0] val);
        @(negedge clock);
        enable    = 1'b1;
        BusMuxOut = val;
        @(negedge clock);
        enable    = 1'b0;
        BusMuxOut = 32'h0;
    endtask

    // Driver: issue a command (mode 0 write, 1 read, 2 both) and act as the
    // memory, acking on request cycle ack_at (0 = never ack). Returns at the
    // first negedge with mem_req low.
    task automatic run_txn(input int mode, input logic [8:0] a, input logic [1:0] sz,
                           input logic sx, input int ack_at, input logic [31:0] rdata);
        @(negedge clock);
        read     = (mode != 0);
        write    = (mode != 1);
        addr     = a;
        size     = sz;
        sign_ext = sx;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        req_cycles = 0;
        saw_done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1'b1;
            if (!mem_req) break;
            req_cycles++;
            if (req_cycles == 1) begin
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_be    = mem_be;
                cap_err   = err;
            end
            if (req_cycles == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
            @(negedge clock);
        end
        mem_ack = 1'b0;
        if (mem_req) check("txn_bound", 32'(mem_req), 32'd0);
    endtask

    initial begin
        clear = 1'b1; enable = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; size = 2'b00; sign_ext = 1'b0; BusMuxOut = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        clear = 1'b0;
        check("rst_bus",   BusMuxIn,        32'h0);
        check("rst_req",   32'(mem_req),    32'd0);
        check("rst_we",    32'(mem_we),     32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_be",    32'(mem_be),     32'd0);
        check("rst_addr",  32'(mem_addr),   32'd0);
        check("rst_state", 32'(fsm_state),  32'd0);

        // MDRin load
        load_mdr(32'hDEADBEEF);
        exp_q.push_back(32'hDEADBEEF);
        check_mdr("en_bus");
        check("en_busy", 32'(busy), 32'd0);

        // Word read, ack on third request cycle
        run_txn(1, 9'h010, 2'b00, 1'b0, 3, 32'h12345678);
        check("rd_req_cycles", 32'(req_cycles), 32'd3);
        check("rd_we",   32'(cap_we),   32'd0);
        check("rd_addr", 32'(cap_addr), 32'h010);
        check("rd_done", 32'(saw_done), 32'd1);
        check("rd_busy", 32'(busy),     32'd0);
        exp_q.push_back(32'h12345678);
        check_mdr("rd_bus");
        @(negedge clock);
        check("rd_done_pulse", 32'(done), 32'd0);

        // Word write, ack on first request cycle
        load_mdr(32'hCAFEF00D);
        run_txn(0, 9'h020, 2'b00, 1'b0, 1, 32'hFFFFFFFF);
        check("wr_req_cycles", 32'(req_cycles), 32'd1);
        check("wr_we",    32'(cap_we),   32'd1);
        check("wr_addr",  32'(cap_addr), 32'h020);
        check("wr_wdata", cap_wdata,     32'hCAFEF00D);
        check("wr_be",    32'(cap_be),   32'hF);
        check("wr_done",  32'(saw_done), 32'd1);
        exp_q.push_back(32'hCAFEF00D);
        check_mdr("wr_bus");

        // Stray ack in IDLE is ignored
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clock);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("idle_ack_done", 32'(done), 32'd0);
        exp_q.push_back(32'hCAFEF00D);
        check_mdr("idle_ack_bus");

        // Read with no ack: abort after 15 wait cycles
        run_txn(1, 9'h030, 2'b00, 1'b0, 0, 32'h0);
        check("to_req_cycles", 32'(req_cycles), 32'd15);
        check("to_err",  32'(err),      32'd1);
        check("to_done", 32'(saw_done), 32'd0);
        exp_q.push_back(32'hCAFEF00D);
        check_mdr("to_bus");
        @(negedge clock);
        check("to_err_sticky", 32'(err), 32'd1);

        // Next accepted read clears err
        run_txn(1, 9'h031, 2'b00, 1'b0, 2, 32'hAAAA5555);
        check("clr_err_first_cycle", 32'(cap_err), 32'd0);
        check("clr_err_after",       32'(err),     32'd0);
        exp_q.push_back(32'hAAAA5555);
        check_mdr("rd2_bus");

        // Read and write together: read wins
        run_txn(2, 9'h040, 2'b00, 1'b0, 1, 32'h0F0F0F0F);
        check("both_we",   32'(cap_we),   32'd0);
        check("both_done", 32'(saw_done), 32'd1);
        exp_q.push_back(32'h0F0F0F0F);
        check_mdr("both_bus");

`ifdef MDR_BYTE_LANES_EN
        // Byte read from lane 2, sign-extended
        run_txn(1, 9'h012, 2'b10, 1'b1, 1, 32'h00800000);
        check("byte_be", 32'(cap_be), 32'h4);
        exp_q.push_back(32'hFFFFFF80);
        check_mdr("byte_sext_bus");

        // Half write to upper lane
        load_mdr(32'h1234BEEF);
        run_txn(0, 9'h002, 2'b01, 1'b0, 1, 32'h0);
        check("half_wr_be",    32'(cap_be), 32'hC);
        check("half_wr_wdata", cap_wdata,   32'hBEEFBEEF);

        // Misaligned half read: err, no request, MDR unchanged
        @(negedge clock);
        read = 1'b1; addr = 9'h001; size = 2'b01;
        @(negedge clock);
        read = 1'b0; size = 2'b00;
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_err", 32'(err),     32'd1);
        check("mis_busy", 32'(busy),   32'd0);
        exp_q.push_back(32'h1234BEEF);
        check_mdr("mis_bus");
`endif

        // Clear during RD_WAIT
        @(negedge clock);
        read = 1'b1; addr = 9'h050;
        @(negedge clock);
        read = 1'b0;
        check("pre_clr_req", 32'(mem_req), 32'd1);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_req",  32'(mem_req), 32'd0);
        check("clr_busy", 32'(busy),    32'd0);
        check("clr_err",  32'(err),     32'd0);
        exp_q.push_back(32'h0);
        check_mdr("clr_bus");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
